vect_prod_sched: RTL and testbench

Job scheduler and sequencer for the shared block-floating-point dot-product engine (vectProd). It arbitrates round-robin between NREQ requesters and grants one job at a time. For the granted job it clears the engine, streams V/P mantissa-pair beats into it, then issues the finish strobe. It captures the engine's result and exponent and returns them to the requester over a valid/ready handshake.

---
 rtl/vect_prod_sched_if.sv | 54 +++++
 rtl/vect_prod_sched.sv | 140 ++++++++++++++
 tb/tb_vect_prod_sched.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vect_prod_sched_if.sv
// Bundle of request, beat, engine and result signals around the dot-product job scheduler.
// master = requesters plus engine side, slave = scheduler.
interface vect_prod_sched_if #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned V    = 16,
    parameter int unsigned P    = 4,
    parameter int unsigned BIT  = 16,
    parameter int unsigned FPM  = 10,
    parameter int unsigned BFPM = 10
);
    localparam int unsigned MW = BFPM + 2;
    localparam int unsigned EW = BIT - FPM - 1;
    localparam int unsigned RW = 2 * MW + $clog2(V);
    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   gnt;
    logic              in_valid;
    logic              in_ready;
    logic [P*MW-1:0]   in_a;
    logic [P*MW-1:0]   in_b;
    logic [EW-1:0]     in_exp_a;
    logic [EW-1:0]     in_exp_b;
    logic              eng_rst;
    logic [P*MW-1:0]   eng_invals;
    logic [P*MW-1:0]   eng_invals2;
    logic              eng_rdy;
    logic              eng_done;
    logic [EW-1:0]     eng_exp;
    logic [EW-1:0]     eng_exp2;
    logic              eng_valid;
    logic [RW-1:0]     eng_prod;
    logic [EW-1:0]     eng_outexp;
    logic              res_valid;
    logic              res_ready;
    logic [IW-1:0]     res_id;
    logic [RW-1:0]     res_prod;
    logic [EW-1:0]     res_exp;
    logic              busy;

    modport master (
        output req, in_valid, in_a, in_b, in_exp_a, in_exp_b,
        output eng_valid, eng_prod, eng_outexp, res_ready,
        input  gnt, in_ready, eng_rst, eng_invals, eng_invals2, eng_rdy, eng_done,
        input  eng_exp, eng_exp2, res_valid, res_id, res_prod, res_exp, busy
    );

    modport slave (
        input  req, in_valid, in_a, in_b, in_exp_a, in_exp_b,
        input  eng_valid, eng_prod, eng_outexp, res_ready,
        output gnt, in_ready, eng_rst, eng_invals, eng_invals2, eng_rdy, eng_done,
        output eng_exp, eng_exp2, res_valid, res_id, res_prod, res_exp, busy
    );
endinterface

// File: rtl/vect_prod_sched.sv
// Round-robin job scheduler for the shared vectProd engine: grants one requester, clears the
// engine, streams B beats into it, strobes finish and hands the captured result back.
module vect_prod_sched #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned V    = 16,
    parameter int unsigned P    = 4,
    parameter int unsigned BIT  = 16,
    parameter int unsigned FPM  = 10,
    parameter int unsigned BFPM = 10
) (
    input logic             clk,
    input logic             reset,
    vect_prod_sched_if.slave bus
);
    localparam int unsigned MW = BFPM + 2;
    localparam int unsigned EW = BIT - FPM - 1;
    localparam int unsigned RW = 2 * MW + $clog2(V);
    localparam int unsigned B  = V / P;
    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = (B > 1) ? $clog2(B) : 1;

    typedef enum logic [2:0] {StIdle, StClear, StFeed, StFinish, StWait, StResp} state_e;

    state_e          state_q;
    logic [NREQ-1:0] gnt_q;
    logic [IW-1:0]   id_q;
    logic [IW-1:0]   ptr_q;
    logic [CW-1:0]   cnt_q;
    logic            eng_rst_q;
    logic            eng_done_q;
    logic            res_valid_q;
    logic [RW-1:0]   prod_q;
    logic [EW-1:0]   res_exp_q;
    logic [EW-1:0]   exp_a_q;
    logic [EW-1:0]   exp_b_q;

    logic            pick_found;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   cand;
    logic            beat;

    // First requesting index at or after the pointer, wrapping around.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = IW'((32'(ptr_q) + i) % NREQ);
            if (!pick_found && bus.req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign beat = (state_q == StFeed) && bus.in_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            gnt_q       <= '0;
            id_q        <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            eng_rst_q   <= 1'b1;
            eng_done_q  <= 1'b0;
            res_valid_q <= 1'b0;
            prod_q      <= '0;
            res_exp_q   <= '0;
            exp_a_q     <= '0;
            exp_b_q     <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // eng_rst is registered, so it is raised here to be high during StClear.
                    eng_rst_q <= pick_found;
                    if (pick_found) begin
                        gnt_q   <= {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
                        id_q    <= pick_idx;
                        state_q <= StClear;
                    end
                end
                StClear: begin
                    eng_rst_q <= 1'b0;
                    cnt_q     <= '0;
                    state_q   <= StFeed;
                end
                StFeed: begin
                    if (beat) begin
                        if (cnt_q == '0) begin
                            exp_a_q <= bus.in_exp_a;
                            exp_b_q <= bus.in_exp_b;
                        end
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CW'(B - 1)) begin
                            eng_done_q <= 1'b1;
                            state_q    <= StFinish;
                        end
                    end
                end
                StFinish: begin
                    eng_done_q <= 1'b0;
                    state_q    <= StWait;
                end
                StWait: begin
                    if (bus.eng_valid) begin
                        prod_q      <= bus.eng_prod;
                        res_exp_q   <= bus.eng_outexp;
                        res_valid_q <= 1'b1;
                        state_q     <= StResp;
                    end
                end
                StResp: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        gnt_q       <= '0;
                        ptr_q       <= (32'(id_q) == NREQ - 1) ? '0 : id_q + 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.in_ready    = (state_q == StFeed);
    assign bus.eng_rst     = eng_rst_q;
    assign bus.eng_invals  = bus.in_a;
    assign bus.eng_invals2 = bus.in_b;
    assign bus.eng_rdy     = beat;
    assign bus.eng_done    = eng_done_q;
    assign bus.eng_exp     = exp_a_q;
    assign bus.eng_exp2    = exp_b_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_id      = id_q;
    assign bus.res_prod    = prod_q;
    assign bus.res_exp     = res_exp_q;
    assign bus.busy        = (state_q != StIdle);
endmodule

// File: tb/tb_vect_prod_sched.sv
// Bench for vect_prod_sched: behavioural engine stub plus directed and randomized jobs, each
// checked against a round-robin / dot-product reference computed from the stimulus arrays.
module tb_vect_prod_sched;
    localparam int unsigned NREQ = 2;
    localparam int unsigned V    = 16;
    localparam int unsigned P    = 4;
    localparam int unsigned BIT  = 16;
    localparam int unsigned FPM  = 10;
    localparam int unsigned BFPM = 10;
    localparam int unsigned MW   = BFPM + 2;
    localparam int unsigned EW   = BIT - FPM - 1;
    localparam int unsigned RW   = 2 * MW + $clog2(V);
    localparam int unsigned B    = V / P;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vect_prod_sched_if #(.NREQ(NREQ), .V(V), .P(P), .BIT(BIT), .FPM(FPM), .BFPM(BFPM)) bus ();

    vect_prod_sched #(.NREQ(NREQ), .V(V), .P(P), .BIT(BIT), .FPM(FPM), .BFPM(BFPM)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Engine stub: accumulates lane products, valid is sticky until eng_rst.
    logic [RW-1:0] e_acc;
    logic [RW-1:0] e_prod;
    logic [EW-1:0] e_exp;
    logic          e_valid;

    function automatic logic [RW-1:0] beat_dot(input logic [P*MW-1:0] a, input logic [P*MW-1:0] b);
        logic [RW-1:0] s;
        s = '0;
        for (int l = 0; l < P; l++) s = s + RW'(a[l*MW +: MW]) * RW'(b[l*MW +: MW]);
        return s;
    endfunction

    always @(posedge clk) begin
        if (bus.eng_rst) begin
            e_acc   <= '0;
            e_valid <= 1'b0;
        end else begin
            if (bus.eng_rdy) e_acc <= e_acc + beat_dot(bus.eng_invals, bus.eng_invals2);
            if (bus.eng_done) begin
                e_valid <= 1'b1;
                e_prod  <= e_acc;
                e_exp   <= bus.eng_exp + bus.eng_exp2;
            end
        end
    end

    assign bus.eng_valid  = e_valid;
    assign bus.eng_prod   = e_prod;
    assign bus.eng_outexp = e_exp;

    int n_cmp  = 0;
    int n_fail = 0;
    int rr_ptr = 0;

    logic [P*MW-1:0] da [B];
    logic [P*MW-1:0] db [B];
    logic [EW-1:0]   ea [B];
    logic [EW-1:0]   eb [B];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic fill(input bit directed);
        for (int k = 0; k < B; k++) begin
            if (directed) begin
                for (int l = 0; l < P; l++) begin
                    da[k][l*MW +: MW] = MW'(2);
                    db[k][l*MW +: MW] = MW'(3);
                end
                ea[k] = (k == 0) ? EW'(3) : EW'(9);
                eb[k] = (k == 0) ? EW'(5) : EW'(9);
            end else begin
                da[k] = (P*MW)'({$urandom(), $urandom()});
                db[k] = (P*MW)'({$urandom(), $urandom()});
                ea[k] = EW'($urandom());
                eb[k] = EW'($urandom());
            end
        end
    endtask

    // One job: vpat bit n = drive a beat on the n-th FEED cycle (all ones above bit 31).
    task automatic do_job(input logic [NREQ-1:0] mask, input bit directed, input logic [31:0] vpat,
                          input int hold, input bit drop_req, input int abort_at);
        longint          s;
        logic [RW-1:0]   ref_prod;
        logic [EW-1:0]   ref_exp;
        logic [NREQ-1:0] want_gnt;
        int idx, t, sent, fc, rst_cnt, done_cnt, rdy_cnt, overlap, gnt_bad;
        fill(directed);
        s = 0;
        for (int k = 0; k < B; k++)
            for (int l = 0; l < P; l++)
                s += longint'(da[k][l*MW +: MW]) * longint'(db[k][l*MW +: MW]);
        ref_prod = RW'(s);
        ref_exp  = EW'(ea[0] + eb[0]);
        idx = -1;
        for (int i = 0; i < NREQ; i++) begin
            int j;
            j = (rr_ptr + i) % NREQ;
            if (idx < 0 && ((mask >> j) & 1) != 0) idx = j;
        end
        want_gnt = NREQ'(1 << idx);
        t = 0; sent = 0; fc = 0; rst_cnt = 0; done_cnt = 0; rdy_cnt = 0; overlap = 0; gnt_bad = 0;
        bus.req = mask;
        while (bus.res_valid !== 1'b1 && t < 300) begin
            if (abort_at > 0 && sent == abort_at) begin
                reset = 1'b0;
                #1;
                chk("abort_gnt", 64'(bus.gnt), 64'(0));
                chk("abort_eng_rst", 64'(bus.eng_rst), 64'(1));
                chk("abort_busy", 64'(bus.busy), 64'(0));
                chk("abort_res", 64'({bus.res_valid, bus.eng_done, bus.in_ready}), 64'(0));
                chk("abort_data", 64'({bus.res_id, bus.res_prod, bus.res_exp}), 64'(0));
                bus.in_valid = 1'b0;
                bus.req      = '0;
                rr_ptr       = 0;
                @(negedge clk);
                reset = 1'b1;
                repeat (2) @(negedge clk);
                return;
            end
            if (drop_req && sent == 2) bus.req = '0;
            bus.in_a     = (P*MW)'({$urandom(), $urandom()});
            bus.in_b     = (P*MW)'({$urandom(), $urandom()});
            bus.in_exp_a = EW'($urandom());
            bus.in_exp_b = EW'($urandom());
            bus.in_valid = 1'b0;
            if (bus.in_ready === 1'b1 && sent < B) begin
                if (fc >= 32 || vpat[fc[4:0]]) begin
                    bus.in_valid = 1'b1;
                    bus.in_a     = da[sent];
                    bus.in_b     = db[sent];
                    bus.in_exp_a = ea[sent];
                    bus.in_exp_b = eb[sent];
                    sent++;
                end
                fc++;
            end
            #1;
            if (bus.eng_rdy === 1'b1) rdy_cnt++;
            if (bus.eng_rst === 1'b1) rst_cnt++;
            if (bus.eng_done === 1'b1) done_cnt++;
            if (bus.eng_rdy === 1'b1 && bus.eng_done === 1'b1) overlap++;
            if (t >= 1 && bus.gnt !== want_gnt) gnt_bad++;
            @(negedge clk);
            t++;
        end
        bus.in_valid = 1'b0;
        chk("res_valid_rise", 64'(bus.res_valid), 64'(1));
        chk("gnt", 64'(bus.gnt), 64'(want_gnt));
        chk("res_id", 64'(bus.res_id), 64'(idx));
        chk("res_prod", 64'(bus.res_prod), 64'(ref_prod));
        chk("res_exp", 64'(bus.res_exp), 64'(ref_exp));
        chk("eng_rst_pulses", 64'(rst_cnt), 64'(1));
        chk("eng_done_pulses", 64'(done_cnt), 64'(1));
        chk("eng_rdy_pulses", 64'(rdy_cnt), 64'(B));
        chk("rdy_done_overlap", 64'(overlap), 64'(0));
        chk("gnt_held", 64'(gnt_bad), 64'(0));
        if (vpat == 32'hFFFF_FFFF) chk("latency", 64'(t), 64'(B + 4));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", 64'(bus.res_valid), 64'(1));
            chk("hold_prod", 64'(bus.res_prod), 64'(ref_prod));
            chk("hold_gnt", 64'(bus.gnt), 64'(want_gnt));
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        chk("after_xfer", 64'({bus.res_valid, bus.gnt, bus.busy}), 64'(0));
        rr_ptr = (idx + 1) % NREQ;
    endtask

    initial begin
        reset         = 1'b0;
        bus.req       = '0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_exp_a  = '0;
        bus.in_exp_b  = '0;
        bus.res_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_gnt", 64'(bus.gnt), 64'(0));
        chk("rst_eng_rst", 64'(bus.eng_rst), 64'(1));
        chk("rst_flags", 64'({bus.res_valid, bus.eng_done, bus.busy, bus.in_ready}), 64'(0));
        chk("rst_data", 64'({bus.res_id, bus.res_prod, bus.res_exp, bus.eng_exp}), 64'(0));
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_eng_rst", 64'(bus.eng_rst), 64'(0));

        // Directed single job: 96 / 8 / id 0, back-to-back beats.
        do_job(2'b01, 1'b1, 32'hFFFF_FFFF, 0, 1'b0, 0);
        bus.req = '0;
        repeat (2) @(negedge clk);
        // Three back-to-back jobs with both requesting.
        rr_ptr = rr_ptr;
        do_job(2'b11, 1'b0, 32'hFFFF_FFFF, 0, 1'b0, 0);
        do_job(2'b11, 1'b0, 32'hFFFF_FFFF, 0, 1'b0, 0);
        do_job(2'b11, 1'b1, 32'hFFFF_FFFF, 0, 1'b0, 0);
        bus.req = '0;
        repeat (2) @(negedge clk);
        // Gapped beats (FEED cycles 0,3,4,9) and a held-off result.
        do_job(2'b10, 1'b1, 32'h0000_0219, 5, 1'b0, 0);
        bus.req = '0;
        repeat (2) @(negedge clk);
        // Reset mid-FEED after two beats, then a clean job.
        do_job(2'b10, 1'b1, 32'hFFFF_FFFF, 0, 1'b0, 2);
        do_job(2'b01, 1'b1, 32'hFFFF_FFFF, 0, 1'b0, 0);
        bus.req = '0;
        repeat (2) @(negedge clk);
        // Request dropped after beat 1.
        do_job(2'b10, 1'b0, 32'hFFFF_FFFF, 2, 1'b1, 0);
        bus.req = '0;
        repeat (2) @(negedge clk);
        for (int n = 0; n < 12; n++) begin
            logic [NREQ-1:0] m;
            m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            do_job(m, 1'b0, $urandom() | 32'h1, int'($urandom_range(0, 3)), 1'b0, 0);
            if ($urandom_range(0, 1) == 0) begin
                bus.req = '0;
                repeat (int'($urandom_range(1, 3))) @(negedge clk);
            end
        end
        bus.req = '0;
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
